blk_146d9a: RTL and testbench

//  Sequencing controller that time-shares one external HxH approximate sub-multiplier
//  (the ap1/ap2/ap3 quadrant units) to form an NxN product over four cycles.
//  Per operand pair it issues LL, LH, HL, HH quadrant requests, selects the quadrant

---
 rtl/blk_146d9a.sv | 119 +++++++++++
 tb/tb_blk_146d9a.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/blk_146d9a.sv
// Sequencing controller: forms an NxN product by time-sharing one external HxH
// sub-multiplier over four quadrant cycles (LL, LH, HL, HH) with shift-accumulate.
module blk_146d9a #(
  parameter int N = 8  // must be even; H is derived from it
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic [N/2-1:0]   pp_a,
  output logic [N/2-1:0]   pp_b,
  output logic [1:0]       pp_sel,
  input  logic [N-1:0]     pp_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_prod,
  output logic             busy
);
  localparam int H = N / 2;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds valid and data stable until that edge.
  typedef enum logic [2:0] {IDLE, S_LL, S_LH, S_HL, S_HH, DONE} state_t;

  state_t         state;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_next;
  logic [2*N-1:0] pp_ext;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign pp_ext   = {{N{1'b0}}, pp_prod};

  // Quadrant operands are combinational so the sub-multiplier answers in the same cycle.
  always_comb begin
    pp_a     = '0;
    pp_b     = '0;
    pp_sel   = 2'd0;
    acc_next = acc;
    case (state)
      S_LL: begin
        pp_a     = a_q[H-1:0];
        pp_b     = b_q[H-1:0];
        pp_sel   = 2'd0;
        acc_next = pp_ext;
      end
      S_LH: begin
        pp_a     = a_q[H-1:0];
        pp_b     = b_q[N-1:H];
        pp_sel   = 2'd1;
        acc_next = acc + (pp_ext << H);
      end
      S_HL: begin
        pp_a     = a_q[N-1:H];
        pp_b     = b_q[H-1:0];
        pp_sel   = 2'd2;
        acc_next = acc + (pp_ext << H);
      end
      S_HH: begin
        pp_a     = a_q[N-1:H];
        pp_b     = b_q[N-1:H];
        pp_sel   = 2'd3;
        acc_next = acc + (pp_ext << N);
      end
      default: ;
    endcase
  end

  // Sums wrap mod 2^(2N): approximate sub-products may overflow and that is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            state <= S_LL;
          end
        end
        S_LL: begin
          acc   <= acc_next;
          state <= S_LH;
        end
        S_LH: begin
          acc   <= acc_next;
          state <= S_HL;
        end
        S_HL: begin
          acc   <= acc_next;
          state <= S_HH;
        end
        S_HH: begin
          acc       <= acc_next;
          out_prod  <= acc_next;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blk_146d9a.sv
// Bench for blk_146d9a: directed steps plus a few random pairs, results checked
// through an expected-value queue popped on each output handshake.
module tb_blk_146d9a;
  localparam int N = 8;
  localparam int H = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [H-1:0]   pp_a;
  logic [H-1:0]   pp_b;
  logic [1:0]     pp_sel;
  logic [N-1:0]   pp_prod;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_prod;
  logic           busy;
  logic           force_ff;

  logic [2*N-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Exact 4x4 sub-multiplier, or a stuck-at-0xFF one for the wrap test.
  assign pp_prod = force_ff ? 8'hFF : ({4'b0, pp_a} * {4'b0, pp_b});

  blk_146d9a #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .pp_a(pp_a), .pp_b(pp_b), .pp_sel(pp_sel), .pp_prod(pp_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic f);
    logic [15:0] q;
    if (!f) return {8'b0, x} * {8'b0, y};
    q = 16'h00FF + (16'h00FF << 4) + (16'h00FF << 4) + (16'h00FF << 8);
    return q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a pair until accepted; returns just after the accepting edge.
  task automatic send(input logic [7:0] av, input logic [7:0] bv);
    int ok;
    ok = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) check("accept_timeout", {31'b0, in_ready}, 1);
    step();
    in_valid = 1'b0;
  endtask

  // Sends a pair and walks the four quadrant cycles plus the first DONE cycle.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp);
    send(av, bv);
    exp_q.push_back(exp);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("busy_in_op", {31'b0, busy}, 1);
      check("out_valid_latency", {31'b0, out_valid}, (i == 5) ? 1 : 0);
      if (i <= 4) begin
        check("pp_sel", {30'b0, pp_sel}, i - 1);
        check("pp_a", {28'b0, pp_a}, (i <= 2) ? {28'b0, av[3:0]} : {28'b0, av[7:4]});
        check("pp_b", {28'b0, pp_b}, (i == 1 || i == 3) ? {28'b0, bv[3:0]} : {28'b0, bv[7:4]});
      end else begin
        check("in_ready_done", {31'b0, in_ready}, 0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_result", {31'b0, out_valid}, 0);
      else check("out_prod", {16'b0, out_prod}, {16'b0, exp_q.pop_front()});
    end
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    int lat;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0; force_ff = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_prod", {16'b0, out_prod}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_pp_sel", {30'b0, pp_sel}, 0);
    step();

    // 0xFF * 0xFF through the exact model
    out_ready = 1'b1;
    run_op(8'hFF, 8'hFF, 16'hFE01);
    step();
    @(negedge clk);
    check("idle_after_hs", {31'b0, in_ready}, 1);
    check("out_valid_dropped", {31'b0, out_valid}, 0);
    check("out_prod_kept", {16'b0, out_prod}, 32'h0000_FE01);
    step();

    // quadrant ordering for 0x12 * 0x34
    run_op(8'h12, 8'h34, 16'h03A8);
    step();

    // stuck sub-product wraps the 2N-bit accumulator
    force_ff = 1'b1;
    run_op(8'h5A, 8'hC3, 16'h1FDF);
    step();
    force_ff = 1'b0;

    // sink stalls for 10 cycles in DONE
    out_ready = 1'b0;
    run_op(8'h9C, 8'h27, model(8'h9C, 8'h27, 1'b0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_valid", {31'b0, out_valid}, 1);
      check("stall_out_prod", {16'b0, out_prod}, 32'h0000_17C4);
      check("stall_in_ready", {31'b0, in_ready}, 0);
      check("stall_busy", {31'b0, busy}, 1);
    end
    step();
    out_ready = 1'b1;
    step();

    // reset during S_LH aborts the pair
    send(8'h77, 8'h55);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_lh", {30'b0, pp_sel}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'b0, in_ready}, 1);
    check("abort_out_valid", {31'b0, out_valid}, 0);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_out_prod", {16'b0, out_prod}, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_result", {31'b0, out_valid}, 0);
    end
    step();

    // back-to-back pairs with in_valid held high; operand changes while busy ignored
    in_valid = 1'b1; a = 8'h3B; b = 8'hD6;
    exp_q.push_back(model(8'h3B, 8'hD6, 1'b0));
    @(negedge clk);
    check("b2b_first_ready", {31'b0, in_ready}, 1);
    step();
    a = 8'hE5; b = 8'h4F;
    exp_q.push_back(model(8'hE5, 8'h4F, 1'b0));
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check("b2b_first_latency", lat, 5);
    @(negedge clk);
    check("b2b_idle_gap", {31'b0, in_ready}, 1);
    @(negedge clk);
    check("b2b_second_accepted", {31'b0, busy}, 1);
    check("b2b_second_pp_a", {28'b0, pp_a}, 5);
    check("b2b_second_pp_b", {28'b0, pp_b}, 32'hF);
    in_valid = 1'b0;
    lat = 0;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check("b2b_second_latency", lat, 5);
    step();

    // random pairs with random sink stalls
    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      out_ready = 1'b0;
      run_op(ra, rb, model(ra, rb, 1'b0));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("rand_hold", {31'b0, out_valid}, 1);
      end
      step();
      out_ready = 1'b1;
      step();
    end

    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
